// File: rtl/prefetch_pkg.sv
// Shared types and default sizing for the prefetch fetcher slice.
// Contents: FSM state enum and default address width / queue depth.
package prefetch_pkg;

    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_QUEUE_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/prefetch_credit_ctr.sv
// Outstanding-read tracker and queue credit check for the prefetch fetcher.
// Ports:
//   clk, rst              clock, async active-high reset
//   grant                 request accepted by memory this cycle
//   rvalid                read response this cycle (ignored when nothing is outstanding)
//   q_count               current prefetch queue occupancy
//   outstanding           registered count of granted-but-unanswered reads
//   outstanding_nz_next_c count will be non-zero after this cycle's grant/response
//   credit_ok_c           queue occupancy plus outstanding reads leaves room for one more
//   rvalid_accept_c       response is legitimate (something was outstanding)
module prefetch_credit_ctr
    import prefetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grant,
    input  logic             rvalid,
    input  logic [CNT_W-1:0] q_count,
    output logic [CNT_W-1:0] outstanding,
    output logic             outstanding_nz_next_c,
    output logic             credit_ok_c,
    output logic             rvalid_accept_c
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;

    // A response with nothing outstanding is a protocol error and is dropped.
    assign rvalid_accept_c = rvalid && (outstanding_q != '0);

    // Extra sum bit keeps a full queue plus in-flight reads from wrapping.
    assign credit_ok_c = (SUM_W'(q_count) + SUM_W'(outstanding_q)) < SUM_W'(QUEUE_DEPTH);

    // Simultaneous grant and response cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        if (grant && !rvalid_accept_c) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!grant && rvalid_accept_c) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding           = outstanding_q;
    assign outstanding_nz_next_c = (outstanding_d != '0);

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction-stream prefetcher: issues sequential byte reads into a prefetch
// queue, throttled by queue credit, with redirect/stop handling that drains
// in-flight reads before switching streams.
// Optional feature: define PREFETCH_FETCHER_PERF_EN to add perf_discard.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start_valid, start_addr  redirect pulse and target byte address
//   stop                     stop fetching, go idle once drained
//   mem_req, mem_addr        read request (held until granted) and its address
//   mem_gnt                  request accepted
//   mem_rvalid, mem_rdata    in-order read response
//   q_enqueue, q_data        byte push into the prefetch queue
//   q_count                  prefetch queue occupancy
//   q_flush                  queue clear pulse, same cycle as an accepted redirect
//   perf_discard             (PREFETCH_FETCHER_PERF_EN) saturating discarded-response count
//   busy                     block is not idle
module prefetch_fetcher
    import prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              q_enqueue,
    output logic [7:0]        q_data,
    input  logic [CNT_W-1:0]  q_count,
    output logic              q_flush,
`ifdef PREFETCH_FETCHER_PERF_EN
    output logic [15:0]       perf_discard,
`endif
    output logic              busy
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_redir_q, pend_redir_d;

    logic [CNT_W-1:0]  outstanding;
    logic              outstanding_nz_next_c;
    logic              credit_ok_c;
    logic              rvalid_accept_c;
    logic              grant_c;

    assign grant_c = mem_req && mem_gnt;

    prefetch_credit_ctr #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_credit (
        .clk                   (clk),
        .rst                   (rst),
        .grant                 (grant_c),
        .rvalid                (mem_rvalid),
        .q_count               (q_count),
        .outstanding           (outstanding),
        .outstanding_nz_next_c (outstanding_nz_next_c),
        .credit_ok_c           (credit_ok_c),
        .rvalid_accept_c       (rvalid_accept_c)
    );

    // State and fetch-pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_ptr_q  <= '0;
            pend_addr_q  <= '0;
            pend_redir_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_ptr_q  <= fetch_ptr_d;
            pend_addr_q  <= pend_addr_d;
            pend_redir_q <= pend_redir_d;
        end
    end

    // Next state. In FETCH the decision to drain uses the post-cycle outstanding
    // count so that a grant coinciding with the redirect is also drained.
    // start_valid always wins over stop.
    always_comb begin
        state_d      = state_q;
        fetch_ptr_d  = fetch_ptr_q;
        pend_addr_d  = pend_addr_q;
        pend_redir_d = pend_redir_q;
        if (grant_c) begin
            fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d     = FETCH;
                    fetch_ptr_d = start_addr;
                end
            end
            FETCH: begin
                if (start_valid) begin
                    if (outstanding_nz_next_c) begin
                        state_d      = DRAIN;
                        pend_addr_d  = start_addr;
                        pend_redir_d = 1'b1;
                    end else begin
                        fetch_ptr_d = start_addr;
                    end
                end else if (stop) begin
                    if (outstanding_nz_next_c) begin
                        state_d      = DRAIN;
                        pend_redir_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    if (start_valid) begin
                        state_d     = FETCH;
                        fetch_ptr_d = start_addr;
                    end else if (stop || !pend_redir_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = FETCH;
                        fetch_ptr_d = pend_addr_q;
                    end
                end else if (start_valid) begin
                    pend_addr_d  = start_addr;
                    pend_redir_d = 1'b1;
                end else if (stop) begin
                    pend_redir_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        mem_req   = 1'b0;
        q_enqueue = 1'b0;
        q_data    = 8'h00;
        busy      = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = credit_ok_c;
                q_enqueue = rvalid_accept_c;
                q_data    = mem_rdata;
                busy      = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr = fetch_ptr_q;
    assign q_flush  = start_valid && !rst;

`ifdef PREFETCH_FETCHER_PERF_EN
    logic [15:0] perf_discard_q, perf_discard_d;

    // Count responses dropped while draining, saturating at all-ones.
    always_comb begin
        perf_discard_d = perf_discard_q;
        if ((state_q == DRAIN) && rvalid_accept_c && (perf_discard_q != 16'hFFFF)) begin
            perf_discard_d = perf_discard_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_discard_q <= 16'h0000;
        end else begin
            perf_discard_q <= perf_discard_d;
        end
    end

    assign perf_discard = perf_discard_q;
`endif

endmodule

// File: tb/tb_prefetch_fetcher.sv
// Self-checking bench for prefetch_fetcher: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model of the fetcher.
module tb_prefetch_fetcher;

    localparam int AW = 16;
    localparam int QD = 4;
    localparam int CW = 3;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic [AW-1:0] start_addr;
    logic          stop;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [7:0]    mem_rdata;
    logic          q_enqueue;
    logic [7:0]    q_data;
    logic [CW-1:0] q_count;
    logic          q_flush;
    logic          busy;
`ifdef PREFETCH_FETCHER_PERF_EN
    logic [15:0]   perf_discard;
`endif

    prefetch_fetcher dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_addr  (start_addr),
        .stop        (stop),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .q_enqueue   (q_enqueue),
        .q_data      (q_data),
        .q_count     (q_count),
        .q_flush     (q_flush),
`ifdef PREFETCH_FETCHER_PERF_EN
        .perf_discard(perf_discard),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment: prefetch queue contents and memory in-flight responses.
    logic [7:0]    qbuf[$];
    logic [7:0]    mem_pend[$];
    logic [AW-1:0] gnt_log[$];
    int            gnt_mode;
    int            rv_mode;
    int            enq_cnt;

    // Behavioural model of the fetcher.
    int            m_st;
    int            m_out;
    logic [AW-1:0] m_ptr;
    logic [AW-1:0] m_pend;
    bit            m_redir;

    logic          obs_req, obs_enq, obs_busy;
    logic [AW-1:0] obs_addr;
    logic [7:0]    obs_data;
    logic [27:0]   obs_vec, exp_vec;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic model_reset();
        m_st    = M_IDLE;
        m_out   = 0;
        m_ptr   = '0;
        m_pend  = '0;
        m_redir = 1'b0;
    endtask

    // Drive one cycle, sample outputs, produce the model's expectation and
    // advance model and environment across the clock edge.
    task automatic cycle(input bit sv, input logic [AW-1:0] sa, input bit sp, input bit deq);
        logic e_req, e_grant, e_racc, e_enq;
        int   n_out;
        @(negedge clk);
        start_valid = sv;
        start_addr  = sa;
        stop        = sp;
        case (gnt_mode)
            0:       mem_gnt = 1'b0;
            1:       mem_gnt = 1'b1;
            default: mem_gnt = ($urandom_range(0, 3) != 0);
        endcase
        if (mem_pend.size() != 0 && (rv_mode == 1 || (rv_mode == 2 && $urandom_range(0, 1) == 1))) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_pend[0];
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 8'($urandom);
        end
        #1;
        obs_req  = mem_req;
        obs_addr = mem_addr;
        obs_enq  = q_enqueue;
        obs_data = q_data;
        obs_busy = busy;
        obs_vec  = {obs_req, obs_req ? obs_addr : 16'h0, obs_enq, obs_enq ? obs_data : 8'h0, q_flush, obs_busy};

        e_req   = (m_st == M_FETCH) && ((int'(q_count) + m_out) < QD);
        e_grant = e_req && mem_gnt;
        e_racc  = mem_rvalid && (m_out > 0);
        e_enq   = (m_st == M_FETCH) && e_racc;
        exp_vec = {e_req, e_req ? m_ptr : 16'h0, e_enq, e_enq ? mem_rdata : 8'h0, sv, (m_st != M_IDLE)};

        n_out = m_out + int'(e_grant) - int'(e_racc);
        if (e_grant) m_ptr = m_ptr + 16'd1;
        case (m_st)
            M_IDLE: begin
                if (sv) begin m_st = M_FETCH; m_ptr = sa; end
            end
            M_FETCH: begin
                if (sv) begin
                    if (n_out > 0) begin m_st = M_DRAIN; m_pend = sa; m_redir = 1'b1; end
                    else m_ptr = sa;
                end else if (sp) begin
                    if (n_out > 0) begin m_st = M_DRAIN; m_redir = 1'b0; end
                    else m_st = M_IDLE;
                end
            end
            default: begin
                if (m_out == 0) begin
                    if (sv) begin m_st = M_FETCH; m_ptr = sa; end
                    else if (sp || !m_redir) m_st = M_IDLE;
                    else begin m_st = M_FETCH; m_ptr = m_pend; end
                end else if (sv) begin
                    m_pend = sa; m_redir = 1'b1;
                end else if (sp) begin
                    m_redir = 1'b0;
                end
            end
        endcase
        m_out = n_out;

        @(posedge clk);
        #1;
        if (mem_rvalid) void'(mem_pend.pop_front());
        if (obs_req && mem_gnt) begin
            mem_pend.push_back(mem_byte(obs_addr));
            gnt_log.push_back(obs_addr);
        end
        if (sv) qbuf.delete();
        if (deq && qbuf.size() > 0) void'(qbuf.pop_front());
        if (obs_enq) begin
            enq_cnt++;
            if (qbuf.size() < QD) qbuf.push_back(obs_data);
        end
        q_count = CW'(qbuf.size());
    endtask

    task automatic test_reset();
        rst = 1'b1; start_valid = 1'b1; start_addr = 16'hABCD; stop = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'hA5; q_count = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_checks++; if (q_enqueue !== 1'b0) begin n_fail++; $display("FAIL reset_q_enqueue: got %b want 0", q_enqueue); end
        n_checks++; if (q_data !== 8'h0) begin n_fail++; $display("FAIL reset_q_data: got %h want 00", q_data); end
        n_checks++; if (q_flush !== 1'b0) begin n_fail++; $display("FAIL reset_q_flush: got %b want 0", q_flush); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        start_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        logic [AW-1:0] got;
        gnt_mode = 1; rv_mode = 1; gnt_log.delete(); enq_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(i == 0, 16'h0100, 1'b0, 1'b0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL fill cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        n_checks++; if (gnt_log.size() != 4) begin n_fail++; $display("FAIL fill_req_count: got %0d want 4", gnt_log.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < gnt_log.size()) ? gnt_log[i] : 16'hxxxx;
            n_checks++; if (got !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL fill_addr%0d: got %h want %h", i, got, 16'h0100 + 16'(i)); end
        end
        n_checks++; if (enq_cnt != 4) begin n_fail++; $display("FAIL fill_enq_count: got %0d want 4", enq_cnt); end
        #1;
        n_checks++; if ({mem_req, q_count} !== {1'b0, 3'd4}) begin n_fail++; $display("FAIL fill_full: got req=%b cnt=%0d want req=0 cnt=4", mem_req, q_count); end
    endtask

    task automatic test_credit();
        logic [AW-1:0] got;
        gnt_log.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0, 1'b0, i == 0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL credit cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        got = (gnt_log.size() > 0) ? gnt_log[0] : 16'hxxxx;
        n_checks++; if (gnt_log.size() != 1 || got !== 16'h0104) begin n_fail++; $display("FAIL credit_one_req: got n=%0d addr=%h want n=1 addr=0104", gnt_log.size(), got); end
    endtask

    task automatic test_redirect();
        logic [AW-1:0] got;
        gnt_mode = 1; rv_mode = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(i == 0, 16'h1000, 1'b0, 1'b0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL redir_setup cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        gnt_mode = 0; gnt_log.delete(); enq_cnt = 0;
        cycle(1'b1, 16'h2000, 1'b0, 1'b0);
        n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL redir_pulse: got %h want %h", obs_vec, exp_vec); end
        n_checks++; if (mem_pend.size() != 2) begin n_fail++; $display("FAIL redir_outstanding: got %0d want 2", mem_pend.size()); end
        gnt_mode = 1; rv_mode = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL redir_drain cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        n_checks++; if (enq_cnt != 0 || gnt_log.size() != 0) begin n_fail++; $display("FAIL redir_discard: got enq=%0d req=%0d want 0 0", enq_cnt, gnt_log.size()); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL redir_resume cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        got = (gnt_log.size() > 0) ? gnt_log[0] : 16'hxxxx;
        n_checks++; if (got !== 16'h2000) begin n_fail++; $display("FAIL redir_first_addr: got %h want 2000", got); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] got;
        logic [AW-1:0] want;
        logic [AW-1:0] wrap_exp[4];
        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
        gnt_mode = 1; rv_mode = 0;
        cycle(1'b1, 16'hFFFE, 1'b0, 1'b0);
        n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL wrap_start: got %h want %h", obs_vec, exp_vec); end
        gnt_log.delete(); rv_mode = 1;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL wrap cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        n_checks++; if (gnt_log.size() != 4) begin n_fail++; $display("FAIL wrap_req_count: got %0d want 4", gnt_log.size()); end
        for (int i = 0; i < 4; i++) begin
            got  = (i < gnt_log.size()) ? gnt_log[i] : 16'hxxxx;
            want = wrap_exp[i];
            n_checks++; if (got !== want) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_stop();
        gnt_mode = 0; rv_mode = 0;
        cycle(1'b1, 16'h3000, 1'b0, 1'b0);
        n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stop_start: got %h want %h", obs_vec, exp_vec); end
        gnt_mode = 1;
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stop_grant: got %h want %h", obs_vec, exp_vec); end
        gnt_mode = 0; enq_cnt = 0;
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stop_cmd: got %h want %h", obs_vec, exp_vec); end
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        n_checks++; if ({obs_busy, obs_req} !== 2'b10) begin n_fail++; $display("FAIL stop_drain: got busy=%b req=%b want busy=1 req=0", obs_busy, obs_req); end
        rv_mode = 1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stop cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
            if (obs_busy === 1'b0) break;
        end
        n_checks++; if (obs_busy !== 1'b0 || enq_cnt != 0) begin n_fail++; $display("FAIL stop_idle: got busy=%b enq=%0d want busy=0 enq=0", obs_busy, enq_cnt); end
    endtask

    task automatic test_reset_mid();
        gnt_mode = 1; rv_mode = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(i == 0, 16'h4000, 1'b0, 1'b0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rstmid_setup cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        @(negedge clk);
        start_valid = 1'b1; start_addr = 16'h7777; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'h3C;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, mem_addr, q_enqueue, q_data, q_flush, busy} !== 28'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got req=%b addr=%h enq=%b data=%h flush=%b busy=%b want all 0",
                     mem_req, mem_addr, q_enqueue, q_data, q_flush, busy);
        end
        model_reset();
        @(negedge clk);
        start_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        rst = 1'b0;
        gnt_mode = 0; rv_mode = 1; enq_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(i == 0, 16'h5000, 1'b0, 1'b0);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rstmid_late cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
        n_checks++; if (enq_cnt != 0) begin n_fail++; $display("FAIL rstmid_late_enq: got %0d want 0", enq_cnt); end
        gnt_mode = 1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b1);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rstmid_resume cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_random();
        bit            sv, sp, dq;
        logic [AW-1:0] sa;
        gnt_mode = 2; rv_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            sv = ($urandom_range(0, 24) == 0);
            sp = ($urandom_range(0, 29) == 0);
            dq = ($urandom_range(0, 1) == 1);
            sa = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
            cycle(sv, sa, sp, dq);
            n_checks++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        gnt_mode = 0;
        rv_mode  = 0;
        enq_cnt  = 0;
        model_reset();
        test_reset();
        test_fill();
        test_credit();
        test_redirect();
        test_wrap();
        test_stop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
